// File: rtl/unlock_pkg.sv
// Shared types and default timing for the lock actuator sequencer.
// State and requester encodings are fixed so that they are stable for software and debug.
package unlock_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        OPEN_DRV  = 3'd1,
        HOLD      = 3'd2,
        CLOSE_DRV = 3'd3,
        COOL      = 3'd4
    } state_e;

    typedef enum logic {
        CPU = 1'b0,
        BTN = 1'b1
    } req_id_e;

    localparam int PULSE_CYC_DEF = 32'd50000;
    localparam int HOLD_CYC_DEF  = 32'd5000000;
    localparam int COOL_CYC_DEF  = 32'd1000000;
    localparam int CNT_W_DEF     = 32'd24;

endpackage

// File: rtl/unlock_seq_ctrl_if.sv
// Request/grant and actuator signals between the I/O register block, the sequencer and the motor driver.
// The master side raises requests; the slave side is the sequencer.
interface unlock_seq_ctrl_if;

    logic cpu_req;
    logic btn_req;
    logic cpu_lock;
    logic grant_cpu;
    logic grant_btn;
    logic req_drop;
    logic motor_fwd;
    logic motor_rev;
    logic is_unlocked;
    logic busy;

    modport master (
        output cpu_req, btn_req, cpu_lock,
        input  grant_cpu, grant_btn, req_drop, motor_fwd, motor_rev, is_unlocked, busy
    );

    modport slave (
        input  cpu_req, btn_req, cpu_lock,
        output grant_cpu, grant_btn, req_drop, motor_fwd, motor_rev, is_unlocked, busy
    );

endinterface

// File: rtl/dwell_timer.sv
// Dwell counter for the timed sequencer states.
// done flags the last cycle of a dwell of 'limit' cycles measured from the most recent clear.
module dwell_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] count_r;

    // Count restarts on every state entry and otherwise advances once per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    assign done = (count_r == (limit - CNT_W'(1)));

endmodule

// File: rtl/unlock_seq_ctrl.sv
// Arbitrates cpu/button unlock requests and runs the actuator through open, hold, close and cooldown.
// All outputs are registered from the next-state decode, so they line up with the state they describe.
module unlock_seq_ctrl
    import unlock_pkg::*;
#(
    parameter int PULSE_CYC = PULSE_CYC_DEF,
    parameter int HOLD_CYC  = HOLD_CYC_DEF,
    parameter int COOL_CYC  = COOL_CYC_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    unlock_seq_ctrl_if.slave   bus
);

    state_e           state_r;
    state_e           state_next_s;
    req_id_e          last_grant_r;
    req_id_e          last_grant_next_s;
    logic [CNT_W-1:0] limit_s;
    logic             clear_s;
    logic             done_s;
    logic             any_req_s;
    logic             grant_cpu_s;
    logic             grant_btn_s;

    logic grant_cpu_r;
    logic grant_btn_r;
    logic req_drop_r;
    logic motor_fwd_r;
    logic motor_rev_r;
    logic is_unlocked_r;
    logic busy_r;

    assign any_req_s = bus.cpu_req | bus.btn_req;
    assign clear_s   = (state_next_s != state_r);

    dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell_timer (
        .clk   (clk),
        .reset (reset),
        .clear (clear_s),
        .limit (limit_s),
        .done  (done_s)
    );

    // Next state, dwell limit and round-robin arbitration for the idle state
    always_comb begin
        state_next_s      = state_r;
        last_grant_next_s = last_grant_r;
        grant_cpu_s       = 1'b0;
        grant_btn_s       = 1'b0;
        limit_s           = CNT_W'(PULSE_CYC);
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_next_s = OPEN_DRV;
                    if (bus.cpu_req && (!bus.btn_req || (last_grant_r == BTN))) begin
                        grant_cpu_s       = 1'b1;
                        last_grant_next_s = CPU;
                    end else begin
                        grant_btn_s       = 1'b1;
                        last_grant_next_s = BTN;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            OPEN_DRV: begin
                limit_s = CNT_W'(PULSE_CYC);
                if (done_s) begin
                    state_next_s = HOLD;
                end else begin
                    state_next_s = OPEN_DRV;
                end
            end
            HOLD: begin
                limit_s = CNT_W'(HOLD_CYC);
                if (done_s || bus.cpu_lock) begin
                    state_next_s = CLOSE_DRV;
                end else begin
                    state_next_s = HOLD;
                end
            end
            CLOSE_DRV: begin
                limit_s = CNT_W'(PULSE_CYC);
                if (done_s) begin
                    state_next_s = COOL;
                end else begin
                    state_next_s = CLOSE_DRV;
                end
            end
            COOL: begin
                limit_s = CNT_W'(COOL_CYC);
                if (done_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = COOL;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State and arbitration history; a reset leaves the button as last winner so cpu takes the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            last_grant_r <= BTN;
        end else begin
            state_r      <= state_next_s;
            last_grant_r <= last_grant_next_s;
        end
    end

    // Output registers decoded from the next state so a reset drops the motor at the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cpu_r   <= 1'b0;
            grant_btn_r   <= 1'b0;
            req_drop_r    <= 1'b0;
            motor_fwd_r   <= 1'b0;
            motor_rev_r   <= 1'b0;
            is_unlocked_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            grant_cpu_r   <= grant_cpu_s;
            grant_btn_r   <= grant_btn_s;
            req_drop_r    <= (state_r != IDLE) && any_req_s;
            motor_fwd_r   <= (state_next_s == OPEN_DRV);
            motor_rev_r   <= (state_next_s == CLOSE_DRV);
            is_unlocked_r <= (state_next_s == HOLD);
            busy_r        <= (state_next_s != IDLE);
        end
    end

    assign bus.grant_cpu   = grant_cpu_r;
    assign bus.grant_btn   = grant_btn_r;
    assign bus.req_drop    = req_drop_r;
    assign bus.motor_fwd   = motor_fwd_r;
    assign bus.motor_rev   = motor_rev_r;
    assign bus.is_unlocked = is_unlocked_r;
    assign bus.busy        = busy_r;

endmodule

// File: tb/tb_unlock_seq_ctrl.sv
// Bench for unlock_seq_ctrl with short timing: directed scenarios against fixed timelines,
// then random traffic against an elapsed-time reference model.
module tb_unlock_seq_ctrl;

    localparam int P = 4;
    localparam int H = 8;
    localparam int C = 3;
    localparam int W = 24;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    unlock_seq_ctrl_if bus ();

    unlock_seq_ctrl #(
        .PULSE_CYC (P),
        .HOLD_CYC  (H),
        .COOL_CYC  (C),
        .CNT_W     (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Observed vector order: grant_cpu, grant_btn, req_drop, motor_fwd, motor_rev, is_unlocked, busy
    logic [6:0] obs_s;
    assign obs_s = {bus.grant_cpu, bus.grant_btn, bus.req_drop, bus.motor_fwd,
                    bus.motor_rev, bus.is_unlocked, bus.busy};

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: e_m counts cycles since the grant became visible (0 = idle),
    // hend_m is the last elapsed cycle of the hold window.
    int         e_m        = 0;
    int         hend_m     = P + H;
    logic       last_btn_m = 1'b1;
    logic [6:0] exp_v      = 7'd0;

    // Expected outputs o cycles after a lone cpu request, straight from the reference timeline
    function automatic logic [6:0] nominal_exp(input int o);
        return {o == 1, 1'b0, 1'b0, (o >= 1 && o <= 4), (o >= 13 && o <= 16),
                (o >= 5 && o <= 12), (o >= 1 && o <= 19)};
    endfunction

    task automatic tick(input logic c, input logic b, input logic l, input logic r);
        logic g_cpu;
        logic g_btn;
        logic drop;
        bus.cpu_req  = c;
        bus.btn_req  = b;
        bus.cpu_lock = l;
        reset        = r;
        @(posedge clk);
        g_cpu = 1'b0;
        g_btn = 1'b0;
        drop  = 1'b0;
        if (r) begin
            e_m        = 0;
            last_btn_m = 1'b1;
        end else if (e_m == 0) begin
            if (c || b) begin
                if (c && (!b || last_btn_m)) begin
                    g_cpu      = 1'b1;
                    last_btn_m = 1'b0;
                end else begin
                    g_btn      = 1'b1;
                    last_btn_m = 1'b1;
                end
                e_m    = 1;
                hend_m = P + H;
            end
        end else begin
            drop = c || b;
            if (l && e_m > P && e_m <= hend_m) hend_m = e_m;
            e_m = e_m + 1;
            if (e_m > hend_m + P + C) e_m = 0;
        end
        exp_v = {g_cpu, g_btn, drop, (e_m >= 1 && e_m <= P),
                 (e_m > hend_m && e_m <= hend_m + P), (e_m > P && e_m <= hend_m), e_m != 0};
        #1;
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1);
            n_checks++;
            if (obs_s !== 7'd0) begin
                n_fails++;
                $display("FAIL reset_hold cyc %0d got %b exp %b", i, obs_s, 7'd0);
            end
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_s !== 7'd0) begin
            n_fails++;
            $display("FAIL reset_release got %b exp %b", obs_s, 7'd0);
        end
    endtask

    task automatic test_nominal();
        do_reset();
        for (int t = 0; t < 21; t++) begin
            tick(t == 0, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs_s !== nominal_exp(t + 1)) begin
                n_fails++;
                $display("FAIL nominal cyc %0d got %b exp %b", t + 1, obs_s, nominal_exp(t + 1));
            end
        end
    endtask

    task automatic test_tie();
        logic [6:0] e;
        do_reset();
        for (int t = 0; t < 21; t++) begin
            tick((t == 0) || (t == 20), (t == 0) || (t == 20), 1'b0, 1'b0);
            e = (t + 1 == 21) ? 7'b0101001 : nominal_exp(t + 1);
            n_checks++;
            if (obs_s !== e) begin
                n_fails++;
                $display("FAIL tie cyc %0d got %b exp %b", t + 1, obs_s, e);
            end
        end
    endtask

    task automatic test_drop();
        logic [6:0] e;
        do_reset();
        for (int t = 0; t < 21; t++) begin
            tick(t == 0, t == 7, 1'b0, 1'b0);
            e = nominal_exp(t + 1) | ((t + 1 == 8) ? 7'b0010000 : 7'b0000000);
            n_checks++;
            if (obs_s !== e) begin
                n_fails++;
                $display("FAIL drop cyc %0d got %b exp %b", t + 1, obs_s, e);
            end
        end
    endtask

    task automatic test_early_relock();
        logic [6:0] e;
        int         o;
        do_reset();
        for (int t = 0; t < 16; t++) begin
            tick(t == 0, 1'b0, (t == 2) || (t == 7), 1'b0);
            o = t + 1;
            e = {o == 1, 1'b0, 1'b0, (o >= 1 && o <= 4), (o >= 8 && o <= 11),
                 (o >= 5 && o <= 7), (o >= 1 && o <= 14)};
            n_checks++;
            if (obs_s !== e) begin
                n_fails++;
                $display("FAIL early_relock cyc %0d got %b exp %b", o, obs_s, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] e;
        int         o;
        do_reset();
        for (int t = 0; t < 26; t++) begin
            tick((t == 0) || (t == 5), 1'b0, 1'b0, t == 2);
            o = t + 1;
            if (o <= 2)      e = nominal_exp(o);
            else if (o <= 5) e = 7'd0;
            else             e = nominal_exp(o - 5);
            n_checks++;
            if (obs_s !== e) begin
                n_fails++;
                $display("FAIL reset_mid cyc %0d got %b exp %b", o, obs_s, e);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            tick($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
            n_checks++;
            if (obs_s !== exp_v) begin
                n_fails++;
                $display("FAIL random cyc %0d got %b exp %b", i, obs_s, exp_v);
            end
            n_checks++;
            if ((bus.motor_fwd & bus.motor_rev) !== 1'b0) begin
                n_fails++;
                $display("FAIL motor_excl cyc %0d got fwd %b rev %b exp not both 1",
                         i, bus.motor_fwd, bus.motor_rev);
            end
        end
    endtask

    initial begin
        bus.cpu_req  = 1'b0;
        bus.btn_req  = 1'b0;
        bus.cpu_lock = 1'b0;
        test_reset();
        test_nominal();
        test_tie();
        test_drop();
        test_early_relock();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
